// File: rtl/s2_output_collector.sv
// Stage-2 output collector: gathers one NFILT x NROW x NCOL frame of results in any order,
// then streams the frame out in linear address order over a valid/ready port.
module s2_output_collector #(
    parameter int NFILT  = 4,
    parameter int NROW   = 6,
    parameter int NCOL   = 6,
    parameter int DWIDTH = 36,
    parameter int AWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [1:0]               wr_filt,
    input  logic [2:0]               wr_row,
    input  logic [2:0]               wr_col,
    input  logic signed [DWIDTH-1:0] wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic signed [DWIDTH-1:0] rd_data,
    output logic [AWIDTH-1:0]        rd_addr,
    output logic                     rd_last,
    output logic                     frame_done,
    output logic                     err_range
);

    localparam int TOTAL  = NFILT * NROW * NCOL;
    localparam int CWIDTH = AWIDTH + 1;

    typedef enum logic {FILL, DRAIN} state_e;

    state_e                   state_q, state_d;
    logic [CWIDTH-1:0]        count_q, count_d;
    logic [TOTAL-1:0]         written_q, written_d;
    logic [AWIDTH-1:0]        rd_ptr_q, rd_ptr_d;
    logic                     frame_done_q, frame_done_d;
    logic                     err_q, err_d;
    logic signed [DWIDTH-1:0] mem_q [TOTAL];

    logic                     in_range;
    logic                     mem_we;
    logic [AWIDTH-1:0]        wr_addr;

    assign in_range = (int'(wr_filt) < NFILT) && (int'(wr_row) < NROW) && (int'(wr_col) < NCOL);
    assign wr_addr  = AWIDTH'(int'(wr_filt) * NROW * NCOL + int'(wr_row) * NCOL + int'(wr_col));
    assign mem_we   = !clr && (state_q == FILL) && wr_valid && in_range;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        written_d    = written_q;
        rd_ptr_d     = rd_ptr_q;
        frame_done_d = 1'b0;
        err_d        = err_q;
        if (clr) begin
            // abort wins over any same-cycle write or read handshake
            state_d   = FILL;
            count_d   = '0;
            written_d = '0;
            rd_ptr_d  = '0;
            err_d     = 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (wr_valid) begin
                        if (!in_range) begin
                            err_d = 1'b1;
                        end else if (!written_q[wr_addr]) begin
                            written_d[wr_addr] = 1'b1;
                            count_d            = count_q + CWIDTH'(1);
                            if (count_d == CWIDTH'(TOTAL)) state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_ready) begin
                        if (rd_ptr_q == AWIDTH'(TOTAL - 1)) begin
                            state_d      = FILL;
                            count_d      = '0;
                            written_d    = '0;
                            rd_ptr_d     = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            rd_ptr_d = rd_ptr_q + AWIDTH'(1);
                        end
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            count_q      <= '0;
            written_q    <= '0;
            rd_ptr_q     <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            written_q    <= written_d;
            rd_ptr_q     <= rd_ptr_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    // Storage needs no reset: every entry is rewritten before it can be read.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_addr] <= wr_data;
    end

    assign wr_ready   = (state_q == FILL);
    assign rd_valid   = (state_q == DRAIN);
    assign rd_addr    = rd_ptr_q;
    assign rd_data    = mem_q[rd_ptr_q];
    assign rd_last    = rd_valid && (rd_ptr_q == AWIDTH'(TOTAL - 1));
    assign frame_done = frame_done_q;
    assign err_range  = err_q;

endmodule

// File: tb/tb_s2_output_collector.sv
// Directed/randomized bench for s2_output_collector against a frame-level reference model.
module tb_s2_output_collector;

    localparam int TOTAL = 144;

    logic        clk = 1'b0;
    logic        rst_n, clr, wr_valid, rd_ready;
    logic [1:0]  wr_filt;
    logic [2:0]  wr_row, wr_col;
    logic [35:0] wr_data;
    logic        wr_ready, rd_valid, rd_last, frame_done, err_range;
    logic [35:0] rd_data;
    logic [7:0]  rd_addr;

    int          vectors = 0;
    int          miscompares = 0;

    // reference model: frame contents, which addresses have been written, sticky error
    logic [35:0] exp_mem [TOTAL];
    bit          exp_written [TOTAL];
    bit          exp_err;
    int          order [TOTAL];

    s2_output_collector #(.NFILT(4), .NROW(6), .NCOL(6), .DWIDTH(36), .AWIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_filt(wr_filt), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_addr(rd_addr),
        .rd_last(rd_last), .frame_done(frame_done), .err_range(err_range)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] rnd36();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[35:0];
    endfunction

    function automatic bit frame_full();
        for (int i = 0; i < TOTAL; i++) if (!exp_written[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < TOTAL; i++) exp_written[i] = 1'b0;
    endtask

    task automatic shuffle_order();
        int j, t;
        for (int i = 0; i < TOTAL; i++) order[i] = i;
        for (int i = TOTAL - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
    endtask

    task automatic do_write(input int f, input int r, input int c, input logic [35:0] d);
        @(negedge clk);
        chk("wr_ready_fill", {63'd0, wr_ready}, {63'd0, !frame_full()});
        chk("err_range_fill", {63'd0, err_range}, {63'd0, exp_err});
        wr_valid = 1'b1;
        wr_filt  = f[1:0];
        wr_row   = r[2:0];
        wr_col   = c[2:0];
        wr_data  = d;
        @(posedge clk);
        if (f < 4 && r < 6 && c < 6) begin
            exp_mem[f*36 + r*6 + c]     = d;
            exp_written[f*36 + r*6 + c] = 1'b1;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic write_addr(input int a, input logic [35:0] d);
        do_write(a / 36, (a % 36) / 6, a % 6, d);
    endtask

    // stall=1 applies rd_ready 1,0,0,1 and random ignored writes; stops once stop_at entries moved
    task automatic drain(input bit stall, input int stop_at);
        int k = 0;
        int cyc = 0;
        while (k < stop_at && cyc < 2000) begin
            @(negedge clk);
            chk("rd_valid", {63'd0, rd_valid}, 64'd1);
            chk("wr_ready_drain", {63'd0, wr_ready}, 64'd0);
            chk("rd_addr", {56'd0, rd_addr}, k);
            chk("rd_data", {28'd0, rd_data}, {28'd0, exp_mem[k]});
            chk("rd_last", {63'd0, rd_last}, {63'd0, k == TOTAL - 1});
            chk("err_range_drain", {63'd0, err_range}, {63'd0, exp_err});
            rd_ready = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            wr_valid = stall ? 1'($urandom_range(1, 0)) : 1'b0;
            wr_filt  = 2'($urandom_range(3, 0));
            wr_row   = 3'($urandom_range(5, 0));
            wr_col   = 3'($urandom_range(5, 0));
            wr_data  = rnd36();
            cyc++;
            @(posedge clk);
            if (rd_ready) k++;
        end
        chk("drain_budget", k, stop_at);
        @(negedge clk);
        rd_ready = 1'b0;
        wr_valid = 1'b0;
        if (stop_at == TOTAL) begin
            chk("frame_done_pulse", {63'd0, frame_done}, 64'd1);
            chk("rd_valid_after", {63'd0, rd_valid}, 64'd0);
            chk("wr_ready_after", {63'd0, wr_ready}, 64'd1);
            model_clear();
            @(negedge clk);
            chk("frame_done_once", {63'd0, frame_done}, 64'd0);
        end else begin
            chk("rd_addr_hold", {56'd0, rd_addr}, stop_at);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_wr_ready"}, {63'd0, wr_ready}, 64'd1);
        chk({tag, "_rd_valid"}, {63'd0, rd_valid}, 64'd0);
        chk({tag, "_rd_last"}, {63'd0, rd_last}, 64'd0);
        chk({tag, "_rd_addr"}, {56'd0, rd_addr}, 64'd0);
        chk({tag, "_frame_done"}, {63'd0, frame_done}, 64'd0);
        chk({tag, "_err_range"}, {63'd0, err_range}, {63'd0, exp_err});
    endtask

    task automatic ramp_frame();
        for (int a = 0; a < TOTAL; a++) write_addr(a, 36'(a - 70));
        drain(1'b0, TOTAL);
    endtask

    initial begin
        rst_n = 1'b1; clr = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        wr_filt = '0; wr_row = '0; wr_col = '0; wr_data = '0;
        exp_err = 1'b0;
        model_clear();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // raster frame with signed ramp data
        ramp_frame();

        // reverse order, one address rewritten before completion
        for (int a = TOTAL - 1; a >= 0; a--) begin
            write_addr(a, rnd36());
            if (a == 50) do_write(2, 3, 4, 36'(999));
        end
        drain(1'b0, TOTAL);

        // out-of-range write mid-frame, drain with stalls and ignored writes
        for (int a = 0; a < TOTAL; a++) begin
            write_addr(a, rnd36());
            if (a == 60) do_write(0, 6, 0, rnd36());
        end
        drain(1'b1, TOTAL);

        // abort after 50 writes (clr collides with a write), then a full random-order frame
        shuffle_order();
        for (int i = 0; i < 50; i++) write_addr(order[i], rnd36());
        @(negedge clk);
        clr = 1'b1; wr_valid = 1'b1; wr_filt = 2'd3; wr_row = 3'd5; wr_col = 3'd5; wr_data = rnd36();
        @(negedge clk);
        clr = 1'b0; wr_valid = 1'b0;
        model_clear();
        exp_err = 1'b0;
        check_idle("after_clr");
        shuffle_order();
        for (int i = 0; i < TOTAL; i++) write_addr(order[i], rnd36());
        drain(1'b0, TOTAL);

        // asynchronous reset in the middle of a drain
        shuffle_order();
        for (int i = 0; i < TOTAL; i++) write_addr(order[i], rnd36());
        drain(1'b0, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("async_rst_wr_ready", {63'd0, wr_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        exp_err = 1'b0;
        @(negedge clk);
        check_idle("post_rst2");
        ramp_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
